// File: rtl/cpu_code_loader_pkg.sv
// Shared definitions for the boot-time code loader: state encoding, the nop
// word driven during boot_done, and the default image size.
package cpu_code_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_LOAD,
        S_DONE,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    localparam int          WORD_W             = 16;
    localparam logic [15:0] NOP_WORD           = 16'h8000;
    localparam int          DEFAULT_LOAD_WORDS = 1024;

endpackage

// File: rtl/cpu_code_loader_fifo.sv
// code_fifo: synchronous first-word-fall-through FIFO with occupancy count.
// Push while full is accepted only when a pop frees the slot in the same cycle.
module code_fifo
    import cpu_code_loader_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = WORD_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        push,
    input  logic [DATA_W-1:0]           wdata,
    input  logic                        pop,
    output logic [DATA_W-1:0]           rdata,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cpu_code_loader.sv
// Streams a host program image into the stack CPU while holding it in LOAD,
// then pulses boot_done and releases RUN. Define CPU_LOADER_CSUM_EN to require a checksum trailer.
module cpu_code_loader
    import cpu_code_loader_pkg::*;
#(
    parameter int LOAD_WORDS = DEFAULT_LOAD_WORDS,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [15:0] par_o,
    output logic        load_o,
    output logic        run_o,
    output logic        boot_done_o,
    output logic        busy,
    output logic        error,
    output logic [10:0] words_loaded
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t        state_q;
    state_t        state_d;
    logic          fifo_clr;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [15:0]   fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic          start_ok;
    logic          image_pop;
    logic          err_set;
    logic          last_word;
    logic          prime_go;

`ifdef CPU_LOADER_CSUM_EN
    logic [15:0]   csum_q;
    logic [15:0]   trailer;
    logic          trailer_vld;
`endif

    assign start_ok  = start && (state_q inside {S_IDLE, S_RUN, S_ERR});
    assign last_word = (words_loaded == 11'(LOAD_WORDS));
    // Small images never fill the FIFO, so also leave PRIME once the whole image is buffered.
    assign prime_go  = fifo_full || (int'(fifo_count) == LOAD_WORDS);
    assign fifo_clr  = start_ok;
    assign fifo_push = s_valid && s_ready && (state_q inside {S_PRIME, S_LOAD});
    assign busy      = state_q inside {S_PRIME, S_LOAD, S_DONE};

    code_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (fifo_clr),
        .push  (fifo_push),
        .wdata (s_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        s_ready   = 1'b0;
        fifo_pop  = 1'b0;
        image_pop = 1'b0;
        err_set   = 1'b0;
`ifdef CPU_LOADER_CSUM_EN
        trailer     = fifo_rdata;
        trailer_vld = 1'b0;
`endif
        case (state_q)
            S_IDLE, S_RUN, S_ERR: begin
                s_ready = (state_q == S_ERR);
                if (start) state_d = S_PRIME;
            end
            S_PRIME: begin
                s_ready = !fifo_full;
                if (prime_go) begin
                    state_d   = S_LOAD;
                    fifo_pop  = 1'b1;
                    image_pop = 1'b1;
                end
            end
            S_LOAD: begin
                s_ready = !fifo_full;
                if (last_word) begin
                    state_d = S_DONE;
                end else if (fifo_empty) begin
                    err_set = 1'b1;
                    state_d = S_ERR;
                end else begin
                    fifo_pop  = 1'b1;
                    image_pop = 1'b1;
                end
            end
            S_DONE: begin
`ifdef CPU_LOADER_CSUM_EN
                state_d = S_CSUM;
`else
                state_d = S_RUN;
`endif
            end
`ifdef CPU_LOADER_CSUM_EN
            S_CSUM: begin
                // The trailer may already sit in the FIFO if the host ran ahead during LOAD.
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    trailer_vld = 1'b1;
                end else begin
                    s_ready     = 1'b1;
                    trailer     = s_data;
                    trailer_vld = s_valid;
                end
                if (trailer_vld) begin
                    if ((csum_q + trailer) == 16'h0000) begin
                        state_d = S_RUN;
                    end else begin
                        err_set = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_o       <= 1'b0;
            run_o        <= 1'b0;
            boot_done_o  <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            par_o        <= '0;
        end else begin
            load_o      <= (state_d == S_LOAD) || (state_d == S_DONE);
            run_o       <= (state_d == S_RUN);
            boot_done_o <= (state_d == S_DONE);
            if (start_ok)     error <= 1'b0;
            else if (err_set) error <= 1'b1;
            if (start_ok)                     words_loaded <= '0;
            else if (image_pop && !last_word) words_loaded <= words_loaded + 1'b1;
            if (image_pop)                par_o <= fifo_rdata;
            else if (state_d == S_DONE)   par_o <= NOP_WORD;
            else                          par_o <= '0;
        end
    end

`ifdef CPU_LOADER_CSUM_EN
    always_ff @(posedge clk) begin
        if (start_ok)       csum_q <= '0;
        else if (image_pop) csum_q <= csum_q + fifo_rdata;
    end
`endif

endmodule

// File: tb/tb_cpu_code_loader.sv
// Directed bench for cpu_code_loader: a 1024-word instance and an 8-word instance
// share clock and reset; host streams are modelled by the tick/drive_host tasks.
`define CHK(TAG, OBS, EXP) \
    begin \
        checks++; \
        assert ((OBS) === (EXP)) else begin \
            errors++; \
            $error("FAIL %s: observed %0h expected %0h", TAG, OBS, EXP); \
        end \
    end

module tb_cpu_code_loader;

    localparam int LW  = 1024;
    localparam int LW8 = 8;
    localparam int FD  = 16;
`ifdef CPU_LOADER_CSUM_EN
    localparam int TRAILER_WORDS = 1;
`else
    localparam int TRAILER_WORDS = 0;
`endif
    // 0x100..0x107 sums to 0x081C; the trailer cancels it modulo 2^16.
    localparam logic [15:0] TRAILER8 = 16'hF7E4;

    logic        clk = 1'b0;
    logic        rst_n, start, s_valid, s_ready, load_o, run_o, boot_done_o, busy, error;
    logic [15:0] s_data, par_o;
    logic [10:0] words_loaded;
    logic        start8, s_valid8, s_ready8, load8, run8, boot8, busy8, error8;
    logic [15:0] s_data8, par8;
    logic [10:0] wl8;

    int          checks = 0;
    int          errors = 0;
    int          sent, sent8;
    logic        host_en, host8_en, throttle, phase;
    logic [15:0] key, trailer;

    always #5 clk = ~clk;

    cpu_code_loader #(.LOAD_WORDS(LW), .FIFO_DEPTH(FD)) dut (
        .clk (clk), .rst_n (rst_n), .start (start), .s_data (s_data), .s_valid (s_valid),
        .s_ready (s_ready), .par_o (par_o), .load_o (load_o), .run_o (run_o),
        .boot_done_o (boot_done_o), .busy (busy), .error (error), .words_loaded (words_loaded)
    );

    cpu_code_loader #(.LOAD_WORDS(LW8), .FIFO_DEPTH(FD)) dut8 (
        .clk (clk), .rst_n (rst_n), .start (start8), .s_data (s_data8), .s_valid (s_valid8),
        .s_ready (s_ready8), .par_o (par8), .load_o (load8), .run_o (run8),
        .boot_done_o (boot8), .busy (busy8), .error (error8), .words_loaded (wl8)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic drive_host();
        s_valid  = host_en && (sent < LW + TRAILER_WORDS) && (!throttle || phase);
        s_data   = (sent >= LW) ? trailer : (sent[15:0] ^ key);
        s_valid8 = host8_en && (sent8 < LW8 + TRAILER_WORDS);
        s_data8  = (sent8 >= LW8) ? TRAILER8 : (16'h0100 + sent8[15:0]);
    endtask

    task automatic tick();
        logic hs, hs8;
        hs  = s_valid && s_ready;
        hs8 = s_valid8 && s_ready8;
        @(posedge clk);
        #1;
        if (hs)  sent++;
        if (hs8) sent8++;
        phase = ~phase;
        drive_host();
    endtask

    task automatic begin_load(input logic [15:0] k, input logic thr, input logic bad, output int n);
        logic [15:0] sum;
        key      = k;
        throttle = thr;
        host_en  = 1'b0;
        sent     = 0;
        sum      = '0;
        for (int j = 0; j < LW; j++) sum = sum + (j[15:0] ^ k);
        trailer = 16'h0000 - sum + {15'd0, bad};
        start = 1'b1;
        drive_host();
        tick();
        start   = 1'b0;
        host_en = 1'b1;
        drive_host();
        `CHK("start_run_drop", run_o, 1'b0)
        `CHK("start_busy", busy, 1'b1)
        `CHK("start_load_low", load_o, 1'b0)
        `CHK("start_err_clr", error, 1'b0)
        `CHK("start_wl_clr", words_loaded, 11'd0)
        `CHK("prime_ready", s_ready, 1'b1)
        n = 0;
        while (!load_o && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic do_load(input logic [15:0] k, input int abort_at, input logic bad);
        int          n;
        logic [15:0] w;
        begin_load(k, 1'b0, bad, n);
        `CHK("prime_cycles", n, FD + 1)
        for (int i = 0; i < LW; i++) begin
            w = i[15:0] ^ k;
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                `CHK("rst_load_drop", load_o, 1'b0)
                `CHK("rst_run_low", run_o, 1'b0)
                `CHK("rst_busy_low", busy, 1'b0)
                `CHK("rst_wl_clr", words_loaded, 11'd0)
                host_en = 1'b0;
                drive_host();
                tick();
                rst_n = 1'b1;
                tick();
                `CHK("rst_idle_ready", s_ready, 1'b0)
                `CHK("rst_idle_run", run_o, 1'b0)
                return;
            end
            checks++;
            if (load_o !== 1'b1) begin
                errors++;
                $error("FAIL load_high: observed %0h expected 1", load_o);
            end
            checks++;
            if (par_o !== w) begin
                errors++;
                $error("FAIL par_word: observed %0h expected %0h", par_o, w);
            end
            checks++;
            if (words_loaded !== 11'(i + 1)) begin
                errors++;
                $error("FAIL words_loaded: observed %0h expected %0h", words_loaded, i + 1);
            end
            `CHK("boot_low", boot_done_o, 1'b0)
            start = (i == 100 || i == 700);
            tick();
            start = 1'b0;
        end
        `CHK("done_boot", boot_done_o, 1'b1)
        `CHK("done_load", load_o, 1'b1)
        `CHK("done_nop", par_o, 16'h8000)
        `CHK("done_wl", words_loaded, 11'd1024)
        `CHK("done_busy", busy, 1'b1)
        `CHK("done_run_low", run_o, 1'b0)
        tick();
`ifdef CPU_LOADER_CSUM_EN
        `CHK("csum_load_low", load_o, 1'b0)
        `CHK("csum_run_low", run_o, 1'b0)
        `CHK("csum_boot_low", boot_done_o, 1'b0)
        tick();
        if (bad) begin
            `CHK("csum_bad_err", error, 1'b1)
            `CHK("csum_bad_run", run_o, 1'b0)
            `CHK("csum_bad_ready", s_ready, 1'b1)
            return;
        end
`endif
        `CHK("run_high", run_o, 1'b1)
        `CHK("run_load_low", load_o, 1'b0)
        `CHK("run_boot_low", boot_done_o, 1'b0)
        `CHK("run_busy_low", busy, 1'b0)
        `CHK("run_ready_low", s_ready, 1'b0)
        `CHK("run_no_err", error, 1'b0)
        tick();
        `CHK("run_hold", run_o, 1'b1)
        `CHK("run_wl_sat", words_loaded, 11'd1024)
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        start    = 1'b0;
        start8   = 1'b0;
        host_en  = 1'b0;
        host8_en = 1'b0;
        throttle = 1'b0;
        phase    = 1'b0;
        sent     = 0;
        sent8    = 0;
        key      = '0;
        trailer  = '0;
        drive_host();
        tick();
        tick();
        `CHK("reset_par", par_o, 16'h0000)
        `CHK("reset_load", load_o, 1'b0)
        `CHK("reset_run", run_o, 1'b0)
        `CHK("reset_boot", boot_done_o, 1'b0)
        `CHK("reset_busy", busy, 1'b0)
        `CHK("reset_error", error, 1'b0)
        `CHK("reset_wl", words_loaded, 11'd0)
        `CHK("reset_ready", s_ready, 1'b0)
        `CHK("reset8_load", load8, 1'b0)
        `CHK("reset8_run", run8, 1'b0)
        rst_n = 1'b1;
        tick();

        // Clean load from IDLE, then a second image restarted from RUN.
        do_load(16'h0000, -1, 1'b0);
        do_load(16'h5A5A, -1, 1'b0);

        // Host supplies one word every other cycle: the FIFO drains and underruns.
        begin_load(16'h00FF, 1'b1, 1'b0, n);
        `CHK("thr_prime_exit", load_o, 1'b1)
        n = 0;
        while (load_o && n < 2000) begin
            tick();
            n++;
        end
        `CHK("thr_load_cycles", n, 31)
        `CHK("thr_error", error, 1'b1)
        `CHK("thr_run_low", run_o, 1'b0)
        `CHK("thr_boot_low", boot_done_o, 1'b0)
        `CHK("thr_busy_low", busy, 1'b0)
        `CHK("thr_err_ready", s_ready, 1'b1)
        `CHK("thr_wl", words_loaded, 11'd31)
        tick();
        `CHK("thr_err_sticky", error, 1'b1)

        // From ERR, abort with reset at word 500, then reload from IDLE.
        do_load(16'h0F0F, 500, 1'b0);
        do_load(16'h1234, -1, 1'b0);
`ifdef CPU_LOADER_CSUM_EN
        do_load(16'h0042, -1, 1'b1);
`endif

        // Small image: PRIME exits once all 8 words are buffered.
        host8_en = 1'b0;
        sent8    = 0;
        start8   = 1'b1;
        drive_host();
        tick();
        start8   = 1'b0;
        host8_en = 1'b1;
        drive_host();
        `CHK("small_busy", busy8, 1'b1)
        n = 0;
        while (!load8 && n < 100) begin
            tick();
            n++;
        end
        `CHK("small_prime_cycles", n, 9)
        for (int i = 0; i < LW8; i++) begin
            checks++;
            if (load8 !== 1'b1) begin
                errors++;
                $error("FAIL small_load: observed %0h expected 1", load8);
            end
            checks++;
            if (par8 !== 16'h0100 + 16'(i)) begin
                errors++;
                $error("FAIL small_par: observed %0h expected %0h", par8, 16'h0100 + 16'(i));
            end
            checks++;
            if (wl8 !== 11'(i + 1)) begin
                errors++;
                $error("FAIL small_wl: observed %0h expected %0h", wl8, i + 1);
            end
            tick();
        end
        `CHK("small_boot", boot8, 1'b1)
        `CHK("small_done_load", load8, 1'b1)
        `CHK("small_nop", par8, 16'h8000)
        tick();
`ifdef CPU_LOADER_CSUM_EN
        `CHK("small_csum_run_low", run8, 1'b0)
        tick();
`endif
        `CHK("small_run", run8, 1'b1)
        `CHK("small_load_low", load8, 1'b0)
        `CHK("small_no_err", error8, 1'b0)

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
